// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port RAM.
// Optional grant/conflict counters are compiled in with SP_RAM_ARB_STATS_EN.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH       = 10,
    parameter int DATA_WIDTH       = 64,
    parameter int INIT_WAIT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    output logic                  busy,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  ram_clk_en,
    output logic                  ram_rdw_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_mask,
    input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef SP_RAM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_grant0,
    output logic [15:0]           stat_grant1,
    output logic [15:0]           stat_conflict
`endif
);

    // state  | meaning
    // S_INIT | post-reset wait, RAM may still be sweeping
    // S_RUN  | grants allowed while hold = 0
    // S_HOLD | external owner has the RAM, no grants
    typedef enum logic [1:0] {S_INIT, S_RUN, S_HOLD} state_t;

    localparam int CNT_W = (INIT_WAIT_CYCLES > 1) ? $clog2(INIT_WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((INIT_WAIT_CYCLES > 0) ? INIT_WAIT_CYCLES - 1 : 0);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      init_cnt, init_cnt_nxt;
    logic                  last_grant;
    logic                  can_grant, gnt0, gnt1;
    logic                  rd_p1, tag_p1;
    logic                  rsp0_valid_q, rsp1_valid_q;
    logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            S_INIT: begin
                if (INIT_WAIT_CYCLES == 0 || init_cnt == CNT_LAST)
                    state_nxt = S_RUN;
                else
                    init_cnt_nxt = init_cnt + CNT_W'(1);
            end
            S_RUN:   if (hold)  state_nxt = S_HOLD;
            S_HOLD:  if (!hold) state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    // rst_n gates grants so nothing reaches the RAM in the cycle reset is applied
    assign can_grant = rst_n && (state == S_RUN) && !hold;
    assign gnt0      = can_grant && req0_valid && (!req1_valid || last_grant);
    assign gnt1      = can_grant && req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        ram_clk_en  = 1'b0;
        ram_rdw_en  = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        ram_mask    = '0;
        if (gnt0) begin
            ram_clk_en  = 1'b1;
            ram_rdw_en  = req0_we;
            ram_addr    = req0_addr;
            ram_data_in = req0_wdata;
            ram_mask    = req0_wmask;
        end else if (gnt1) begin
            ram_clk_en  = 1'b1;
            ram_rdw_en  = req1_we;
            ram_addr    = req1_addr;
            ram_data_in = req1_wdata;
            ram_mask    = req1_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            rd_p1        <= 1'b0;
            tag_p1       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            if (gnt0) last_grant <= 1'b0;
            if (gnt1) last_grant <= 1'b1;
            rd_p1        <= (gnt0 && !req0_we) || (gnt1 && !req1_we);
            tag_p1       <= gnt1;
            rsp0_valid_q <= rd_p1 && !tag_p1;
            rsp1_valid_q <= rd_p1 && tag_p1;
            if (rd_p1 && !tag_p1) rsp0_rdata_q <= ram_data_out;
            if (rd_p1 && tag_p1)  rsp1_rdata_q <= ram_data_out;
        end
    end

    assign rsp0_valid = rst_n && rsp0_valid_q;
    assign rsp1_valid = rst_n && rsp1_valid_q;
    assign rsp0_rdata = rst_n ? rsp0_rdata_q : '0;
    assign rsp1_rdata = rst_n ? rsp1_rdata_q : '0;
    assign busy       = !rst_n || (state != S_RUN) || rd_p1;

`ifdef SP_RAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (gnt0 && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
            if (gnt1 && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
            if (state == S_RUN && !hold && req0_valid && req1_valid &&
                stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter: directed scenarios then random traffic
// against a cycle-count/queue reference model and a behavioural RAM.
module tb_sp_ram_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int IW = 8;

    logic          clk = 1'b0, rst_n = 1'b0, hold = 1'b0, busy;
    logic          req0_valid = 0, req0_ready, req0_we = 0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req0_wmask = '0;
    logic          req1_valid = 0, req1_ready, req1_we = 0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0, req1_wmask = '0;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          ram_clk_en, ram_rdw_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in, ram_mask, ram_data_out;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_WAIT_CYCLES(IW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .busy(busy),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_clk_en(ram_clk_en), .ram_rdw_en(ram_rdw_en), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_mask(ram_mask), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // behavioural single-port RAM
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_clk_en) begin
            if (ram_rdw_en)
                ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_mask) | (ram_data_in & ram_mask);
            else
                ram_data_out <= ram_mem[ram_addr];
        end
    end

    typedef struct { int id; logic [DW-1:0] data; int due; } exp_t;
    exp_t          sbq[$];
    int            glog[$];
    int            total = 0, bad = 0, cyc = 0, since = 0;
    bit            hold_prev = 0, rd_inflight = 0, rd_granted = 0, last = 1;
    bit            acc [2];
    int            rsp_cnt [2];
    logic [DW-1:0] rsp_seen [2];
    logic [DW-1:0] last_rdata [2];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        acc[0] = 0; acc[1] = 0;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        rsp_seen[0] = '0; rsp_seen[1] = '0;
        last_rdata[0] = '0; last_rdata[1] = '0;
    end

    // model advance at the clock edge
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            since = 0; hold_prev = 0; rd_inflight = 0; last = 1;
            sbq.delete();
            last_rdata[0] = '0; last_rdata[1] = '0;
        end else begin
            since++;
            hold_prev   = hold;
            rd_inflight = rd_granted;
        end
    end

    // request-side monitor: expected grant, RAM command, busy; pushes read expectations
    always @(negedge clk) begin
        bit            in_run, ok, we_g;
        int            g;
        logic [AW-1:0] a_g;
        logic [DW-1:0] d_g, m_g;
        in_run = (since >= IW) && !((since - 1 >= IW) && hold_prev);
        ok     = rst_n && in_run && !hold;
        g      = -1;
        if (ok) begin
            if (req0_valid && req1_valid) g = last ? 0 : 1;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("busy", busy, !rst_n || !in_run || rd_inflight);
        chk("ram_clk_en", ram_clk_en, g >= 0);
        rd_granted = 0;
        acc[0] = (g == 0);
        acc[1] = (g == 1);
        if (g >= 0) begin
            we_g = (g == 0) ? req0_we    : req1_we;
            a_g  = (g == 0) ? req0_addr  : req1_addr;
            d_g  = (g == 0) ? req0_wdata : req1_wdata;
            m_g  = (g == 0) ? req0_wmask : req1_wmask;
            chk("ram_cmd", {ram_rdw_en, ram_addr, ram_data_in, ram_mask}, {we_g, a_g, d_g, m_g});
            last = (g == 1);
            glog.push_back(g);
            if (we_g) ref_mem[a_g] = (ref_mem[a_g] & ~m_g) | (d_g & m_g);
            else begin
                sbq.push_back('{id: g, data: ref_mem[a_g], due: cyc + 2});
                rd_granted = 1;
            end
        end else begin
            chk("ram_idle", {ram_rdw_en, ram_addr, ram_data_in, ram_mask}, 0);
        end
    end

    // response monitor: pops the scoreboard
    always @(negedge clk) begin
        bit   ev [2];
        exp_t e;
        ev[0] = 0; ev[1] = 0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (rst_n) begin
                ev[e.id] = 1;
                last_rdata[e.id] = e.data;
            end
        end
        chk("rsp0_valid", rsp0_valid, ev[0]);
        chk("rsp1_valid", rsp1_valid, ev[1]);
        chk("rsp0_rdata", rsp0_rdata, rst_n ? last_rdata[0] : '0);
        chk("rsp1_rdata", rsp1_rdata, rst_n ? last_rdata[1] : '0);
        if (rsp0_valid) begin rsp_cnt[0]++; rsp_seen[0] = rsp0_rdata; end
        if (rsp1_valid) begin rsp_cnt[1]++; rsp_seen[1] = rsp1_rdata; end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(int n);
        rst_n = 0;
        repeat (n) step();
        rst_n = 1;
    endtask

    task automatic set_req(int id, bit v, bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] m);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_wmask = m;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_wmask = m;
        end
    endtask

    task automatic issue(int id, bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] m);
        bit got = 0;
        int n = 0;
        set_req(id, 1, we, a, d, m);
        while (!got && n < 40) begin
            @(negedge clk); #1;
            got = acc[id];
            step();
            n++;
        end
        if (!got) chk("issue_timeout", 0, 1);
        set_req(id, 0, 0, '0, '0, '0);
    endtask

    task automatic first_ready(int id, output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(negedge clk); #1;
            if (acc[id]) at = since;
            step();
        end
    endtask

    initial begin
        int at, gl;
        bit a0, a1;
        step();

        // init window
        do_reset(3);
        set_req(0, 1, 0, 6'h10, '0, '0);
        first_ready(0, at);
        set_req(0, 0, 0, '0, '0, '0);
        chk("init_wait", at, IW);

        // alternating back-to-back reads from a fresh reset
        do_reset(2);
        glog.delete();
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        set_req(0, 1, 0, 6'h10, '0, '0);
        set_req(1, 1, 0, 6'h20, '0, '0);
        repeat (IW + 8) step();
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        repeat (3) step();
        chk("alt_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("alt_order", glog[i], i % 2);
        chk("alt_rsp0", rsp_cnt[0], 4);
        chk("alt_rsp1", rsp_cnt[1], 4);

        // write then cross-requester read
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        issue(0, 1, 6'd5, 32'hDEAD_BEEF, '1);
        issue(1, 0, 6'd5, '0, '0);
        repeat (4) step();
        chk("wr_rd_cnt1", rsp_cnt[1], 1);
        chk("wr_rd_data", rsp_seen[1], 32'hDEAD_BEEF);
        chk("wr_rd_cnt0", rsp_cnt[0], 0);

        // partial mask
        issue(0, 1, 6'd7, 32'hFFFF_FFFF, '1);
        issue(0, 1, 6'd7, 32'h0, 32'h0000_FFFF);
        issue(1, 0, 6'd7, '0, '0);
        repeat (4) step();
        chk("mask_data", rsp_seen[1], 32'hFFFF_0000);

        // hold raised right after a read is accepted
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        issue(0, 0, 6'd9, '0, '0);
        hold = 1;
        glog.delete();
        set_req(1, 1, 0, 6'd3, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("hold_busy", busy, 1);
            step();
        end
        gl = glog.size();
        chk("hold_nogrant", gl, 0);
        chk("hold_rsp0", rsp_cnt[0], 1);
        hold = 0;
        issue(1, 0, 6'd3, '0, '0);
        repeat (3) step();

        // reset with a read in flight
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        issue(0, 0, 6'd5, '0, '0);
        do_reset(2);
        chk("rst_drop", rsp_cnt[0] + rsp_cnt[1], 0);
        set_req(0, 1, 0, 6'h11, '0, '0);
        first_ready(0, at);
        set_req(0, 0, 0, '0, '0, '0);
        chk("reinit_wait", at, IW);
        repeat (3) step();

        // random traffic with random hold and occasional reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            a0 = acc[0]; a1 = acc[1];
            step();
            for (int id = 0; id < 2; id++) begin
                bit v_now, a_now;
                v_now = (id == 0) ? req0_valid : req1_valid;
                a_now = (id == 0) ? a0 : a1;
                if (v_now && !a_now) begin
                    if ($urandom_range(9) == 0) set_req(id, 0, 0, '0, '0, '0);
                end else begin
                    set_req(id, $urandom_range(2) != 0, 1'($urandom_range(1)),
                            AW'($urandom_range(15)), $urandom,
                            ($urandom_range(1) != 0) ? '1 : $urandom);
                end
            end
            if ($urandom_range(15) == 0) hold = ~hold;
            rst_n = ($urandom_range(499) != 0);
        end
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        hold  = 0;
        rst_n = 1;
        repeat (5) step();
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Two-requester arbiter and sequencer for one single-port RAM instance (the sp_ram toplevel's clk_en/rdw_en/addr/data_in/data_mask_in/data_out interface).
- Converts two independent valid/ready request streams into one RAM command per cycle.
- Uses round-robin arbitration and returns read data with a fixed latency.
- Holds off all traffic during a post-reset wait window, sized to cover the RAM's zero-init sweep.
- Holds off all traffic while an external hold (e.g. JTAG BIST access) is active.

Parameters:
ADDR_WIDTH, 10, RAM address width.
DATA_WIDTH, 64, RAM data and mask width.
INIT_WAIT_CYCLES, 1024, cycles after reset release before any grant. 0 = no wait. Set to 2^ADDR_WIDTH when the RAM zero-inits on reset.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
hold  in  1  1 = suspend new grants
busy  out  1  1 = not in RUN state, or a read is in flight
req0_valid / req1_valid  in  1  request valid
req0_ready / req1_ready  out  1  request accepted this cycle
req0_we / req1_we  in  1  1 = write, 0 = read
req0_addr / req1_addr  in  ADDR_WIDTH  address
req0_wdata / req1_wdata  in  DATA_WIDTH  write data
req0_wmask / req1_wmask  in  DATA_WIDTH  bit write mask, 1 = write bit
rsp0_valid / rsp1_valid  out  1  read data valid, single-cycle pulse
rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data
ram_clk_en  out  1  RAM enable
ram_rdw_en  out  1  1 = WR, 0 = RD
ram_addr  out  ADDR_WIDTH  RAM address
ram_data_in  out  DATA_WIDTH  RAM write data
ram_mask  out  DATA_WIDTH  RAM bit mask
ram_data_out  in  DATA_WIDTH  RAM read data, valid the cycle after a read command

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
- Values while rst_n = 0 and on the first cycle after release:
  - state = INIT, init counter = 0, last_grant = 1.
  - All ready, rsp*_valid, ram_clk_en and ram_rdw_en = 0.
  - rsp*_rdata = 0; busy = 1.
- States:
  - INIT: counts cycles. Goes to RUN when counter == INIT_WAIT_CYCLES-1, or immediately when INIT_WAIT_CYCLES = 0.
  - RUN: goes to HOLD when hold = 1.
  - HOLD: goes to RUN when hold = 0.
- Grants occur only in RUN with hold = 0. hold is checked combinationally, so the first cycle hold rises gives no grant.
- Arbitration (combinational, same cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - last_grant updates on every grant.
- reqN_ready = grant to N. ready never asserts without the matching valid.
- RAM command is combinational from the granted request:
  - ram_clk_en = 1, ram_rdw_en = we, ram_addr / ram_data_in / ram_mask = granted fields.
  - With no grant: ram_clk_en = 0, other ram outputs = 0.
  - For a read, ram_mask and ram_data_in are driven from the request unchanged.
- Read latency:
  - A read accepted at clock edge N has ram_data_out sampled at edge N+1.
  - rspX_valid = 1 and rspX_rdata = sampled data, both registered, during cycle N+2 (exactly two cycles after acceptance).
  - The response goes only to the originating requester, tracked by a one-bit tag pipelined with an in-flight flag.
  - rsp*_rdata holds its last value when valid = 0.
- Writes produce no response.
- Back-to-back reads from alternating requesters are fully pipelined: one response per cycle.
- hold asserted while a read is in flight: that read still completes and responds. busy stays 1 until it does.
- Reset mid-operation: in-flight reads are dropped, no rsp_valid is generated, and the block restarts INIT.
- Requester side effect: a requester may change its fields only after ready. A dropped valid without ready is legal and has no effect.

Optional Feature:
Macro SP_RAM_ARB_STATS_EN.
- Defined: adds outputs stat_grant0, stat_grant1 and stat_conflict, each 16 bits.
  - stat_grant0 / stat_grant1 count grants to each requester.
  - stat_conflict counts cycles in RUN with both valid and hold = 0.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- INIT_WAIT_CYCLES = 8; req0 read held high from reset release -> req0_ready first rises 8 cycles after release; no ram_clk_en before that.
- Both requesters continuously valid, reads to 0x10 and 0x20 -> grants alternate 0,1,0,1 starting with req0; rsp0/rsp1 alternate, each 2 cycles after its grant.
- req0 writes 0xDEAD_BEEF to addr 5 with mask all-ones, then req1 reads addr 5 -> rsp1_rdata = 0xDEAD_BEEF; rsp0_valid never asserts.
- Partial mask: write 0xFFFF_FFFF, then 0x0 with mask 0x0000_FFFF, then read -> 0xFFFF_0000.
- req0 read accepted, hold raised the next cycle -> rsp0_valid still pulses once; no further grants while hold = 1; busy = 1 through hold.
- Read accepted, rst_n pulled low the next cycle -> no rsp_valid; all outputs return to reset values; INIT restarts.
